// File: rtl/telemetry_framer.sv
// rtl/telemetry_framer.sv - byte-stream framer for the PC waveform viewer
//
// Purpose: on each accepted start_in, streams one frame of bytes:
//   "WAVWID" | wave width | "OSCIDX" | osc0..osc(N-1) | "WAVDAT" | samples [| checksum]
//   Index fields are IDX_B=ceil(IDX_WIDTH/8) bytes, samples SMP_B=ceil(SAMPLE_WIDTH/8)
//   bytes, zero-extended and sent MSB byte first. Samples are read from wave memory
//   one at a time, starting at start_idx and wrapping at the end of the wave.
//
// Optional feature: define FRAMER_CHECKSUM_EN to append one trailer byte holding the
//   XOR of every preceding byte of the frame (tags included).
//
// Ports:
//   clk_in, rst_in                clock, synchronous active-high reset
//   start_in                      frame request (only honoured in IDLE)
//   wave_width_in, start_idx_in   wave length and window start, snapshotted at accept
//   osc_indices_in                packed playback indices, osc 0 in the LSBs
//   rd_en_out, rd_addr_out        wave memory read strobe / address
//   rd_data_in                    read data, valid MEM_LATENCY cycles after rd_en_out
//   byte_out, byte_valid_out      output byte stream
//   byte_ready_in                 sink ready (transfer = valid & ready at posedge)
//   busy_out                      frame in progress
//   frame_done_out                one-cycle pulse after the last byte transfers

module telemetry_framer #(
  parameter int NUM_OSC      = 4,
  parameter int IDX_WIDTH    = 18,
  parameter int SAMPLE_WIDTH = 16,
  parameter int MAX_SAMPLES  = 1024,
  parameter int MEM_LATENCY  = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic [IDX_WIDTH-1:0]         wave_width_in,
  input  logic [IDX_WIDTH-1:0]         start_idx_in,
  input  logic [NUM_OSC*IDX_WIDTH-1:0] osc_indices_in,
  output logic                         rd_en_out,
  output logic [IDX_WIDTH-1:0]         rd_addr_out,
  input  logic [SAMPLE_WIDTH-1:0]      rd_data_in,
  output logic [7:0]                   byte_out,
  output logic                         byte_valid_out,
  input  logic                         byte_ready_in,
  output logic                         busy_out,
  output logic                         frame_done_out
);

  localparam int IDX_B  = (IDX_WIDTH + 7) / 8;
  localparam int SMP_B  = (SAMPLE_WIDTH + 7) / 8;
  localparam int IDX_PW = IDX_B * 8;
  localparam int SMP_PW = SMP_B * 8;

  localparam logic [47:0] TAG_WW = 48'h57_41_56_57_49_44;  // "WAVWID"
  localparam logic [47:0] TAG_OI = 48'h4F_53_43_49_44_58;  // "OSCIDX"
  localparam logic [47:0] TAG_WD = 48'h57_41_56_44_41_54;  // "WAVDAT"

  localparam logic [2:0] TAG_LAST  = 3'd5;
  localparam logic [2:0] IDX_LAST  = 3'(IDX_B - 1);
  localparam logic [2:0] SMP_LAST  = 3'(SMP_B - 1);
  localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 1);
  localparam logic [4:0] OSC_LAST  = 5'(NUM_OSC - 1);

  // Window clamp; widths above MAX_SAMPLES are cut to MAX_SAMPLES samples.
  localparam logic [63:0]        MAX64   = 64'(MAX_SAMPLES);
  localparam logic [IDX_WIDTH:0] WIN_MAX = MAX64[IDX_WIDTH:0];

  typedef enum logic [3:0] {
    S_IDLE,
    S_TAG_WW,
    S_FLD_WW,
    S_TAG_OI,
    S_FLD_OI,
    S_TAG_WD,
    S_FETCH,
    S_WAIT,
    S_SEND_SMP
`ifdef FRAMER_CHECKSUM_EN
    , S_TRAILER
`endif
  } state_t;

  // State entered once the sample window is exhausted.
`ifdef FRAMER_CHECKSUM_EN
  localparam state_t S_AFTER = S_TRAILER;
`else
  localparam state_t S_AFTER = S_IDLE;
`endif

  state_t                       state_q, state_d;
  logic [2:0]                   byte_cnt_q;
  logic [4:0]                   osc_cnt_q;
  logic [2:0]                   wait_cnt_q;
  logic [IDX_WIDTH-1:0]         width_q;
  logic [IDX_WIDTH-1:0]         cur_q;
  logic [IDX_WIDTH-1:0]         rd_addr_q;
  logic [NUM_OSC*IDX_WIDTH-1:0] osc_q;
  logic [IDX_WIDTH:0]           remain_q;
  logic [SAMPLE_WIDTH-1:0]      sample_q;
  logic                         done_q;
`ifdef FRAMER_CHECKSUM_EN
  logic [7:0]                   csum_q;
`endif

  logic       valid_w;
  logic       xfer;
  logic       accept;
  logic [7:0] byte_w;

  function automatic logic [7:0] tag_byte(input logic [47:0] tag, input logic [2:0] k);
    logic [47:0] t;
    t = tag >> (8 * (5 - int'(k)));
    return t[7:0];
  endfunction

  function automatic logic [7:0] idx_byte(input logic [IDX_WIDTH-1:0] v, input logic [2:0] k);
    logic [IDX_PW-1:0] p;
    p = IDX_PW'(v);
    p = p >> (8 * (IDX_B - 1 - int'(k)));
    return p[7:0];
  endfunction

  function automatic logic [7:0] smp_byte(input logic [SAMPLE_WIDTH-1:0] v, input logic [2:0] k);
    logic [SMP_PW-1:0] p;
    p = SMP_PW'(v);
    p = p >> (8 * (SMP_B - 1 - int'(k)));
    return p[7:0];
  endfunction

  // Valid depends only on the registered state, so byte/valid cannot move while stalled.
  always_comb begin
    valid_w = 1'b0;
    case (state_q)
      S_TAG_WW, S_FLD_WW, S_TAG_OI, S_FLD_OI, S_TAG_WD, S_SEND_SMP: valid_w = 1'b1;
`ifdef FRAMER_CHECKSUM_EN
      S_TRAILER: valid_w = 1'b1;
`endif
      default: valid_w = 1'b0;
    endcase
  end

  assign xfer = valid_w & byte_ready_in;

  always_comb begin
    byte_w = 8'h00;
    case (state_q)
      S_TAG_WW:   byte_w = tag_byte(TAG_WW, byte_cnt_q);
      S_FLD_WW:   byte_w = idx_byte(width_q, byte_cnt_q);
      S_TAG_OI:   byte_w = tag_byte(TAG_OI, byte_cnt_q);
      S_FLD_OI:   byte_w = idx_byte(osc_q[IDX_WIDTH-1:0], byte_cnt_q);
      S_TAG_WD:   byte_w = tag_byte(TAG_WD, byte_cnt_q);
      S_SEND_SMP: byte_w = smp_byte(sample_q, byte_cnt_q);
`ifdef FRAMER_CHECKSUM_EN
      S_TRAILER:  byte_w = csum_q;
`endif
      default:    byte_w = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The frame_done cycle swallows start_in so a held request restarts one cycle later.
        if (start_in && !done_q) begin
          state_d = S_TAG_WW;
          accept  = 1'b1;
        end
      end
      S_TAG_WW: if (xfer && byte_cnt_q == TAG_LAST) state_d = S_FLD_WW;
      S_FLD_WW: if (xfer && byte_cnt_q == IDX_LAST) state_d = S_TAG_OI;
      S_TAG_OI: if (xfer && byte_cnt_q == TAG_LAST) state_d = S_FLD_OI;
      S_FLD_OI: if (xfer && byte_cnt_q == IDX_LAST && osc_cnt_q == OSC_LAST) state_d = S_TAG_WD;
      S_TAG_WD: begin
        if (xfer && byte_cnt_q == TAG_LAST)
          state_d = (remain_q == '0) ? S_AFTER : S_FETCH;
      end
      S_FETCH:  state_d = S_WAIT;
      S_WAIT:   if (wait_cnt_q == WAIT_LAST) state_d = S_SEND_SMP;
      S_SEND_SMP: begin
        if (xfer && byte_cnt_q == SMP_LAST)
          state_d = (remain_q == (IDX_WIDTH+1)'(1)) ? S_AFTER : S_FETCH;
      end
`ifdef FRAMER_CHECKSUM_EN
      S_TRAILER: if (xfer) state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      byte_cnt_q <= '0;
      osc_cnt_q  <= '0;
      wait_cnt_q <= '0;
      width_q    <= '0;
      cur_q      <= '0;
      rd_addr_q  <= '0;
      osc_q      <= '0;
      remain_q   <= '0;
      sample_q   <= '0;
      done_q     <= 1'b0;
`ifdef FRAMER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      done_q <= (state_q != S_IDLE) && (state_d == S_IDLE);

      // Byte counter restarts on every state entry; FLD_OI also restarts per oscillator.
      if (state_q != state_d)
        byte_cnt_q <= '0;
      else if (xfer)
        byte_cnt_q <= (state_q == S_FLD_OI && byte_cnt_q == IDX_LAST) ? 3'd0 : byte_cnt_q + 3'd1;

      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 3'd1 : 3'd0;

      if (accept) begin
        width_q   <= wave_width_in;
        osc_q     <= osc_indices_in;
        osc_cnt_q <= '0;
        cur_q     <= (start_idx_in >= wave_width_in) ? '0 : start_idx_in;
        remain_q  <= (64'(wave_width_in) > MAX64) ? WIN_MAX : {1'b0, wave_width_in};
      end

      // Shift the next oscillator field into the low bits once the current one is sent.
      if (state_q == S_FLD_OI && xfer && byte_cnt_q == IDX_LAST) begin
        osc_q     <= osc_q >> IDX_WIDTH;
        osc_cnt_q <= osc_cnt_q + 5'd1;
      end

      if (state_q == S_FETCH) begin
        rd_addr_q <= cur_q;
        cur_q     <= ({1'b0, cur_q} + 1'b1 == {1'b0, width_q}) ? '0 : cur_q + 1'b1;
      end

      if (state_q == S_WAIT && wait_cnt_q == WAIT_LAST)
        sample_q <= rd_data_in;

      if (state_q == S_SEND_SMP && xfer && byte_cnt_q == SMP_LAST)
        remain_q <= remain_q - 1'b1;

`ifdef FRAMER_CHECKSUM_EN
      if (accept)    csum_q <= '0;
      else if (xfer) csum_q <= csum_q ^ byte_w;
`endif
    end
  end

  assign byte_out       = byte_w;
  assign byte_valid_out = valid_w;
  assign busy_out       = (state_q != S_IDLE);
  assign rd_en_out      = (state_q == S_FETCH);
  // Present the fetch address during FETCH itself, then hold it until the next read.
  assign rd_addr_out    = (state_q == S_FETCH) ? cur_q : rd_addr_q;
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// tb/tb_telemetry_framer.sv - testbench for telemetry_framer
`timescale 1ns/1ps

module tb_telemetry_framer;

  localparam int LAT_A = 2;
  localparam int LAT_B = 3;
`ifdef FRAMER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam logic [71:0] OSC0 = {18'd3, 18'd2, 18'd1, 18'd0};
  localparam logic [71:0] OSC1 = {18'h3FFFF, 18'h12345, 18'h00100, 18'h2ABCD};

  typedef logic [7:0]  bq_t[$];
  typedef logic [17:0] aq_t[$];

  typedef struct {
    logic [17:0] w;
    logic [17:0] s;
    logic [71:0] o;
    int          rm;
    logic [17:0] midw;
    logic [15:0] m0;
    int          exp_len;
    int          exp_nrd;
    logic [17:0] exp_rd0;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ready;
  logic [17:0] width, sidx;
  logic [71:0] osc;
  logic        rd_en_a, rd_en_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [17:0] rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic [7:0]  byte_a, byte_b;
  logic [15:0] mem [16];

  telemetry_framer #(.MEM_LATENCY(LAT_A)) dut_a (
    .clk_in(clk), .rst_in(rst), .start_in(start), .wave_width_in(width),
    .start_idx_in(sidx), .osc_indices_in(osc), .rd_en_out(rd_en_a),
    .rd_addr_out(rd_addr_a), .rd_data_in(rd_data_a), .byte_out(byte_a),
    .byte_valid_out(valid_a), .byte_ready_in(ready), .busy_out(busy_a),
    .frame_done_out(done_a));

  telemetry_framer #(.MEM_LATENCY(LAT_B)) dut_b (
    .clk_in(clk), .rst_in(rst), .start_in(start), .wave_width_in(width),
    .start_idx_in(sidx), .osc_indices_in(osc), .rd_en_out(rd_en_b),
    .rd_addr_out(rd_addr_b), .rd_data_in(rd_data_b), .byte_out(byte_b),
    .byte_valid_out(valid_b), .byte_ready_in(ready), .busy_out(busy_b),
    .frame_done_out(done_b));

  // Memory models: data is only meaningful around the posedge ending the
  // MEM_LATENCY-th cycle after the strobe; 16'hDEAD everywhere else.
  logic [LAT_A:0] pv_a = '0;
  logic [17:0]    pa_a [LAT_A+1];
  logic [LAT_B:0] pv_b = '0;
  logic [17:0]    pa_b [LAT_B+1];
  always @(negedge clk) begin
    pv_a    <= {pv_a[LAT_A-1:0], rd_en_a};
    pa_a[0] <= rd_addr_a;
    for (int i = 1; i <= LAT_A; i++) pa_a[i] <= pa_a[i-1];
    pv_b    <= {pv_b[LAT_B-1:0], rd_en_b};
    pa_b[0] <= rd_addr_b;
    for (int i = 1; i <= LAT_B; i++) pa_b[i] <= pa_b[i-1];
  end
  assign rd_data_a = pv_a[LAT_A] ? mem[pa_a[LAT_A][3:0]] : 16'hDEAD;
  assign rd_data_b = pv_b[LAT_B] ? mem[pa_b[LAT_B][3:0]] : 16'hDEAD;

  int   total = 0;
  int   bad = 0;
  int   rmode = 0;
  int   cyc = 0;
  int   ndone_a, ndone_b, stall_viol;
  bq_t  bytes_a, bytes_b, exp_b;
  aq_t  reads_a, reads_b, exp_rd;
  logic hold_v = 1'b0;
  logic [7:0] hold_byte;
  vec_t vecs [7];
  logic [7:0] golden [43] = '{
    8'h57, 8'h41, 8'h56, 8'h57, 8'h49, 8'h44, 8'h00, 8'h00, 8'h05,
    8'h4F, 8'h53, 8'h43, 8'h49, 8'h44, 8'h58,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03,
    8'h57, 8'h41, 8'h56, 8'h44, 8'h41, 8'h54,
    8'hA0, 8'h01, 8'hA0, 8'h02, 8'hA0, 8'h03, 8'hA0, 8'h04, 8'hA0, 8'h00};

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Sink ready: always 1, or high one cycle in three.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // Monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (valid_a && ready) bytes_a.push_back(byte_a);
        if (valid_b && ready) bytes_b.push_back(byte_b);
        if (rd_en_a) reads_a.push_back(rd_addr_a);
        if (rd_en_b) reads_b.push_back(rd_addr_b);
        if (done_a) ndone_a++;
        if (done_b) ndone_b++;
        if (hold_v && (!valid_a || byte_a != hold_byte)) stall_viol++;
        hold_v    = valid_a && !ready;
        hold_byte = byte_a;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic push_tag(input logic [47:0] t);
    for (int k = 5; k >= 0; k--) exp_b.push_back(t[k*8 +: 8]);
  endtask

  task automatic push_idx(input logic [17:0] v);
    logic [23:0] p;
    p = {6'b0, v};
    exp_b.push_back(p[23:16]);
    exp_b.push_back(p[15:8]);
    exp_b.push_back(p[7:0]);
  endtask

  task automatic build_exp(input logic [17:0] w, input logic [17:0] s, input logic [71:0] o);
    logic [17:0] cur;
    logic [15:0] d;
    int n;
    exp_b.delete();
    exp_rd.delete();
    push_tag(48'h574156574944);
    push_idx(w);
    push_tag(48'h4F5343494458);
    for (int i = 0; i < 4; i++) push_idx(o[i*18 +: 18]);
    push_tag(48'h574156444154);
    n = (w > 18'd1024) ? 1024 : int'(w);
    cur = (s >= w) ? 18'd0 : s;
    for (int k = 0; k < n; k++) begin
      exp_rd.push_back(cur);
      d = mem[cur[3:0]];
      exp_b.push_back(d[15:8]);
      exp_b.push_back(d[7:0]);
      cur = (cur + 18'd1 == w) ? 18'd0 : cur + 18'd1;
    end
`ifdef FRAMER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (exp_b[k]) x ^= exp_b[k];
      exp_b.push_back(x);
    end
`endif
  endtask

  function automatic int diff_b(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    foreach (a[k]) if (a[k] != b[k]) return k;
    return -1;
  endfunction

  function automatic int diff_a(input aq_t a, input aq_t b);
    if (a.size() != b.size()) return (a.size() < b.size()) ? a.size() : b.size();
    foreach (a[k]) if (a[k] != b[k]) return k;
    return -1;
  endfunction

  task automatic clear_caps();
    bytes_a.delete(); bytes_b.delete(); reads_a.delete(); reads_b.delete();
    ndone_a = 0; ndone_b = 0; stall_viol = 0;
  endtask

  // One frame: pulse start, change width mid-frame if asked, poke start again
  // while busy (must be ignored), then let both DUTs drain.
  task automatic run_frame(input vec_t v);
    int c;
    clear_caps();
    rmode = v.rm;
    width = v.w; sidx = v.s; osc = v.o;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (c = 0; c < 6000; c++) begin
      if (ndone_a > 0 && ndone_b > 0) break;
      if (c == 5 && v.midw != 18'd0) width = v.midw;
      if (c == 8) start = 1'b1;
      if (c == 9) start = 1'b0;
      @(posedge clk); #1;
    end
    if (c >= 6000) chk("timeout_frame", c, 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input vec_t v);
    build_exp(v.w, v.s, v.o);
    chk("len_a", bytes_a.size(), v.exp_len + CS);
    chk("len_b", bytes_b.size(), v.exp_len + CS);
    chk("data_a_first_diff", diff_b(bytes_a, exp_b), -1);
    chk("data_b_first_diff", diff_b(bytes_b, exp_b), -1);
    chk("nreads_a", reads_a.size(), v.exp_nrd);
    chk("nreads_b", reads_b.size(), v.exp_nrd);
    chk("rdseq_a_first_diff", diff_a(reads_a, exp_rd), -1);
    if (v.exp_nrd > 0 && reads_a.size() > 0) chk("first_rd_addr", reads_a[0], v.exp_rd0);
    chk("done_pulses_a", ndone_a, 1);
    chk("done_pulses_b", ndone_b, 1);
    chk("stall_stability", stall_viol, 0);
  endtask

  initial begin
    int got;
    rst = 1'b1; start = 1'b0; width = '0; sidx = '0; osc = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);

    vecs[0] = '{18'd5, 18'd1, OSC0, 0, 18'd0, 16'hA000, 43, 5, 18'd1};
    vecs[1] = '{18'd5, 18'd1, OSC0, 1, 18'd0, 16'hA000, 43, 5, 18'd1};
    vecs[2] = '{18'd0, 18'd0, OSC1, 1, 18'd0, 16'hA000, 33, 0, 18'd0};
    vecs[3] = '{18'd7, 18'd9, OSC1, 0, 18'd0, 16'hA000, 47, 7, 18'd0};
    vecs[4] = '{18'd3, 18'd2, OSC1, 1, 18'd0, 16'hA000, 39, 3, 18'd2};
    vecs[5] = '{18'd1, 18'd0, 72'd0, 0, 18'd0, 16'h1234, 35, 1, 18'd0};
    vecs[6] = '{18'd5, 18'd1, OSC0, 1, 18'd9, 16'hA000, 43, 5, 18'd1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_byte", byte_a, 0);
    chk("rst_rd_addr", rd_addr_a, 0);
    @(posedge clk); #1; rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      mem[0] = vecs[i].m0;
      run_frame(vecs[i]);
      check_frame(vecs[i]);
      if (i == 0) begin
        got = -1;
        for (int k = 0; k < 43; k++)
          if (got < 0 && (k >= bytes_a.size() || bytes_a[k] != golden[k])) got = k;
        chk("golden_first_diff", got, -1);
      end
`ifdef FRAMER_CHECKSUM_EN
      if (i == 5 && bytes_a.size() > 0) begin
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < bytes_a.size() - 1; k++) x ^= bytes_a[k];
        chk("checksum_byte", bytes_a[bytes_a.size()-1], x);
      end
`endif
    end
    mem[0] = 16'hA000;

    // Reset in the middle of the sample phase, then a fresh frame.
    clear_caps();
    rmode = 0; width = 18'd5; sidx = 18'd1; osc = OSC0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    got = 0;
    for (int c = 0; c < 1000; c++) begin
      if (reads_a.size() >= 2) begin got = 1; break; end
      @(posedge clk); #1;
    end
    chk("midrst_reads_seen", got, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_rd_en", rd_en_a, 0);
    chk("midrst_busy_b", busy_b, 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", ndone_a, 0);
    run_frame(vecs[0]);
    check_frame(vecs[0]);

    // start_in held high: ignored in the frame_done cycle, accepted the next one.
    clear_caps();
    rmode = 0; width = 18'd5; sidx = 18'd1; osc = OSC0;
    @(posedge clk); #1; start = 1'b1;
    got = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_a) begin got = 1; break; end
    end
    chk("hold_done_seen", got, 1);
    chk("hold_busy_done_cycle", busy_a, 0);
    @(negedge clk);
    chk("hold_busy_plus1", busy_a, 0);
    @(negedge clk);
    chk("hold_busy_plus2", busy_a, 1);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (ndone_a >= 2) begin got = 1; break; end
    end
    chk("hold_second_done", got, 1);
    repeat (40) @(posedge clk);
    chk("hold_total_len", bytes_a.size(), 2 * (43 + CS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
